instruction_fetch: RTL and testbench

- Producer side of the instruction register interface.
- Holds the program counter and issues single-word reads to instruction memory.
- Captures the returned 16-bit word and presents it on instruction together with a one-cycle instruction_en pulse. The instruction register latches the word on that pulse.
- Sits between the control FSM (fetch_req, pc_load) and instruction memory.

---
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch producer: holds the PC, issues single-word memory reads and
// pulses instruction_en with the captured word. Optional halt-on-all-ones via FETCH_HALT_EN.
module instruction_fetch #(
  parameter int WIDTH       = 16,
  parameter int ADDR_BITS   = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic                 pc_load,
  input  logic [ADDR_BITS-1:0] pc_load_value,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  output logic [WIDTH-1:0]     instruction,
  output logic                 instruction_en,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 busy,
  output logic                 halted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [3:0] LAT_C = 4'(MEM_LATENCY);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   rd_en_q, rd_en_d;
  logic [WIDTH-1:0]       instr_q, instr_d;
  logic                   instr_en_q, instr_en_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic [3:0]             cnt_q, cnt_d;

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    instr_d    = instr_q;
    instr_en_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_load_value;
        end else if (fetch_req) begin
          addr_d  = pc_q;
          rd_en_d = 1'b1;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        cnt_d   = 4'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT_C) begin
          instr_d    = mem_rdata;
          instr_en_d = 1'b1;
          pc_d       = pc_q + ADDR_BITS'(1);
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
`ifdef FETCH_HALT_EN
        if (instr_q == {WIDTH{1'b1}}) begin
          state_d = S_HALT;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        if (pc_load) begin
          pc_d    = pc_load_value;
          state_d = S_IDLE;
        end else begin
          state_d = S_HALT;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered from the next state so they line up with it.
    busy_d   = (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_DONE);
    halted_d = (state_d == S_HALT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      instr_q    <= '0;
      instr_en_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      instr_q    <= instr_d;
      instr_en_q <= instr_en_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_rd_en      = rd_en_q;
  assign instruction    = instr_q;
  assign instruction_en = instr_en_q;
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch at MEM_LATENCY=1 and 4.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0, pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic [15:0] mem_rdata, mem_addr, instruction, pc;
  logic        mem_rd_en, instruction_en, busy, halted;

  logic        fetch_req4 = 1'b0, pc_load4 = 1'b0;
  logic [15:0] pc_load_value4 = 16'h0000;
  logic [15:0] mem_rdata4, mem_addr4, instruction4, pc4;
  logic        mem_rd_en4, instruction_en4, busy4, halted4;

  logic [15:0] mem [4];
  int n_checks = 0, n_errors = 0;
  int cyc = 0, rd_cnt1 = 0, rd_cnt4 = 0, last_en = 0;

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr[1:0]];
  assign mem_rdata4 = 16'hBEEF ^ mem_addr4;

  // Cycle and read-strobe counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en)  rd_cnt1 <= rd_cnt1 + 1;
    if (mem_rd_en4) rd_cnt4 <= rd_cnt4 + 1;
  end

  instruction_fetch #(.WIDTH(16), .ADDR_BITS(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .instruction(instruction), .instruction_en(instruction_en),
    .pc(pc), .busy(busy), .halted(halted));

  instruction_fetch #(.WIDTH(16), .ADDR_BITS(16), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req4), .pc_load(pc_load4),
    .pc_load_value(pc_load_value4), .mem_rdata(mem_rdata4), .mem_addr(mem_addr4),
    .mem_rd_en(mem_rd_en4), .instruction(instruction4), .instruction_en(instruction_en4),
    .pc(pc4), .busy(busy4), .halted(halted4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch on the latency-1 instance; returns in the IDLE cycle after DONE.
  task automatic do_fetch(input string tag, input logic [15:0] exp_addr, input logic [15:0] exp_word);
    int lat;
    int rd0;
    rd0 = rd_cnt1;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd1);
    check({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, exp_addr});
    lat = 1;
    while (!instruction_en && lat < 20) begin
      step();
      lat++;
    end
    last_en = cyc;
    check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_word"}, {16'd0, instruction}, {16'd0, exp_word});
    step();
    check({tag, "_en_drop"}, {31'd0, instruction_en}, 32'd0);
    check({tag, "_one_strobe"}, rd_cnt1 - rd0, 32'd1);
  endtask

  initial begin
    int t0;
    int lat;
    int rd0;
    mem[0] = 16'h1234; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'h0000;
    step();
    step();
    // Outputs under reset.
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_instr", {16'd0, instruction}, 32'd0);
    check("rst_en", {31'd0, instruction_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc4", {16'd0, pc4}, 32'd0);
    reset = 1'b0;
    step();

    // Single fetch: strobe in cycle 1, pulse in cycle 3 only.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("t1_rd_en_c1", {31'd0, mem_rd_en}, 32'd1);
    check("t1_addr_c1", {16'd0, mem_addr}, 32'd0);
    check("t1_busy_c1", {31'd0, busy}, 32'd1);
    step();
    check("t1_rd_en_c2", {31'd0, mem_rd_en}, 32'd0);
    check("t1_en_c2", {31'd0, instruction_en}, 32'd0);
    check("t1_busy_c2", {31'd0, busy}, 32'd1);
    step();
    check("t1_en_c3", {31'd0, instruction_en}, 32'd1);
    check("t1_instr_c3", {16'd0, instruction}, 32'h1234);
    check("t1_busy_c3", {31'd0, busy}, 32'd1);
    step();
    check("t1_en_c4", {31'd0, instruction_en}, 32'd0);
    check("t1_busy_c4", {31'd0, busy}, 32'd0);
    check("t1_pc", {16'd0, pc}, 32'd1);
    check("t1_instr_hold", {16'd0, instruction}, 32'h1234);

    // Three back-to-back fetches from address 0.
    mem[0] = 16'hA0B1; mem[1] = 16'hC2D3; mem[2] = 16'hE4F5;
    pc_load = 1'b1; pc_load_value = 16'h0000;
    step();
    pc_load = 1'b0;
    check("t2_pc_load", {16'd0, pc}, 32'd0);
    do_fetch("t2_f0", 16'h0000, 16'hA0B1);
    t0 = last_en;
    do_fetch("t2_f1", 16'h0001, 16'hC2D3);
    check("t2_gap1", last_en - t0, 32'd4);
    t0 = last_en;
    do_fetch("t2_f2", 16'h0002, 16'hE4F5);
    check("t2_gap2", last_en - t0, 32'd4);
    check("t2_pc", {16'd0, pc}, 32'd3);

    // pc_load beats fetch_req; then fetch at FFFF wraps pc.
    mem[3] = 16'h5A5A;
    rd0 = rd_cnt1;
    pc_load = 1'b1; pc_load_value = 16'hFFFF; fetch_req = 1'b1;
    step();
    pc_load = 1'b0; fetch_req = 1'b0;
    check("t3_pc", {16'd0, pc}, 32'hFFFF);
    check("t3_busy", {31'd0, busy}, 32'd0);
    step();
    check("t3_no_rd", rd_cnt1 - rd0, 32'd0);
    do_fetch("t3_wrap", 16'hFFFF, 16'h5A5A);
    check("t3_pc_wrap", {16'd0, pc}, 32'd0);

    // All-ones word: halts only when the feature is built in.
    mem[0] = 16'hFFFF; mem[1] = 16'h0BAD;
    do_fetch("t6_ffff", 16'h0000, 16'hFFFF);
    check("t6_pc", {16'd0, pc}, 32'd1);
`ifdef FETCH_HALT_EN
    check("t6_halted", {31'd0, halted}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    rd0 = rd_cnt1;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    check("t6_no_rd", rd_cnt1 - rd0, 32'd0);
    check("t6_still_halted", {31'd0, halted}, 32'd1);
    pc_load = 1'b1; pc_load_value = 16'h0010;
    step();
    pc_load = 1'b0;
    check("t6_unhalt", {31'd0, halted}, 32'd0);
    check("t6_pc_load", {16'd0, pc}, 32'h0010);
`else
    check("t6_not_halted", {31'd0, halted}, 32'd0);
    do_fetch("t6_next", 16'h0001, 16'h0BAD);
    check("t6_pc_next", {16'd0, pc}, 32'd2);
`endif

    // Latency-4 instance, with requests toggled while busy.
    pc_load4 = 1'b1; pc_load_value4 = 16'h0007;
    step();
    pc_load4 = 1'b0;
    check("t4_pc_init", {16'd0, pc4}, 32'h0007);
    rd0 = rd_cnt4;
    fetch_req4 = 1'b1;
    step();
    check("t4_rd_en", {31'd0, mem_rd_en4}, 32'd1);
    check("t4_addr", {16'd0, mem_addr4}, 32'h0007);
    lat = 1;
    pc_load4 = 1'b1; pc_load_value4 = 16'h0040;
    while (!instruction_en4 && lat < 30) begin
      step();
      lat++;
      fetch_req4 = lat[0];
      pc_load4 = ~lat[0];
    end
    fetch_req4 = 1'b0; pc_load4 = 1'b0;
    check("t4_latency", lat, 32'd6);
    check("t4_word", {16'd0, instruction4}, 32'hBEE8);
    check("t4_pc", {16'd0, pc4}, 32'h0008);
    step();
    check("t4_en_drop", {31'd0, instruction_en4}, 32'd0);
    check("t4_pc_after", {16'd0, pc4}, 32'h0008);
    check("t4_one_strobe", rd_cnt4 - rd0, 32'd1);

    // Reset in the capture cycle abandons the read.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_pc", {16'd0, pc}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_instr", {16'd0, instruction}, 32'd0);
    check("t5_addr", {16'd0, mem_addr}, 32'd0);
    check("t5_pc4", {16'd0, pc4}, 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_en", {31'd0, instruction_en}, 32'd0);
    end
    check("t5_instr_after", {16'd0, instruction}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
